// File: rtl/mp_sys_pkg.sv
// Shared constants and types for the multi-port memory subsystem.
package mp_sys_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned N_CORES   = 3;
  localparam int unsigned CORE_ID_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned CNT_W     = 16;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [CORE_ID_W-1:0] core_id_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

endpackage

// File: rtl/mp_rr_arbiter.sv
// Round-robin arbiter; ptr holds the index where the next search starts.
module mp_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      req,
  input  logic                              grant_en,
  output logic [N-1:0]                      gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id
);

  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  logic [ID_W-1:0] ptr;
  logic            found;
  int unsigned     idx;

  // First requester found scanning upward from ptr, wrapping at N.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[ID_W'(idx)]) begin
        found            = 1'b1;
        gnt[ID_W'(idx)]  = 1'b1;
        gnt_id           = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_en && found) begin
      ptr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/mp_mem_system.sv
// N-port byte memory behind a round-robin arbiter, one transaction per 3 cycles.
// Optional per-core completion counters: define MP_SYS_ACCESS_COUNT_EN.
module mp_mem_system #(
  parameter int unsigned N      = mp_sys_pkg::N_CORES,
  parameter int unsigned ADDR_W = mp_sys_pkg::ADDR_W,
  parameter int unsigned DATA_W = mp_sys_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [N-1:0]        mem_req,
  input  logic [N-1:0]        mem_we,
  input  logic [N*ADDR_W-1:0] mem_addr,
  input  logic [N*DATA_W-1:0] mem_write,
  output logic [N-1:0]        mem_ready,
  output logic [N*DATA_W-1:0] mem_read
`ifdef MP_SYS_ACCESS_COUNT_EN
  ,
  output logic [N*16-1:0]     grant_count
`endif
);

  import mp_sys_pkg::*;

  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  state_t              state, state_n;
  logic                grant_en;
  logic [N-1:0]        gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [ID_W-1:0]     lat_id;
  logic [N-1:0]        ready_n;
  logic [N*DATA_W-1:0] read_n;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  mp_rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .rst      (resetN),
    .req      (mem_req),
    .grant_en (grant_en),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (resetN) begin
      state     <= IDLE;
      mem_ready <= '0;
      mem_read  <= '0;
    end else begin
      state     <= state_n;
      mem_ready <= ready_n;
      mem_read  <= read_n;
    end
  end

  // Next state plus next values of the registered ready/read outputs.
  always_comb begin
    state_n  = state;
    grant_en = 1'b0;
    ready_n  = '0;
    read_n   = mem_read;
    case (state)
      IDLE: begin
        grant_en = 1'b1;
        if (|mem_req) state_n = ACCESS;
      end
      ACCESS: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (lat_id == ID_W'(i)) begin
            ready_n[i] = 1'b1;
            if (!lat_we) read_n[i*DATA_W +: DATA_W] = mem[lat_addr];
          end
        end
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Transaction latch: requester inputs are captured once, at grant.
  always_ff @(posedge clk) begin
    if (resetN) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= '0;
    end else if (grant_en && (|mem_req)) begin
      lat_we    <= |(mem_we & gnt);
      lat_addr  <= mem_addr[gnt_id*ADDR_W +: ADDR_W];
      lat_wdata <= mem_write[gnt_id*DATA_W +: DATA_W];
      lat_id    <= gnt_id;
    end
  end

  // Storage is never cleared; a reset on the ACCESS edge cancels the write.
  always_ff @(posedge clk) begin
    if (!resetN && (state == ACCESS) && lat_we) mem[lat_addr] <= lat_wdata;
  end

`ifdef MP_SYS_ACCESS_COUNT_EN
  logic [CNT_W-1:0] acc_cnt [N];

  always_ff @(posedge clk) begin
    if (resetN) begin
      for (int unsigned i = 0; i < N; i++) acc_cnt[i] <= '0;
    end else if (state == ACCESS) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((lat_id == ID_W'(i)) && (acc_cnt[i] != 16'hFFFF))
          acc_cnt[i] <= acc_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < N; i++) grant_count[i*16 +: 16] = acc_cnt[i];
  end
`endif

endmodule

// File: tb/tb_mp_mem_system.sv
// Directed plus random checks of mp_mem_system against a transaction-level model.
module tb_mp_mem_system;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            resetN;
  logic [N-1:0]    mem_req, mem_we, mem_ready;
  logic [N*AW-1:0] mem_addr;
  logic [N*DW-1:0] mem_write, mem_read;
`ifdef MP_SYS_ACCESS_COUNT_EN
  logic [N*16-1:0] grant_count;
`endif

  mp_mem_system dut (
    .clk       (clk),
    .resetN    (resetN),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_ready (mem_ready),
    .mem_read  (mem_read)
`ifdef MP_SYS_ACCESS_COUNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Model: byte array, per-port last read value, next search start, pending requests.
  logic [7:0] ref_mem [256];
  bit         written [256];
  logic [7:0] last_read [N];
  int         rr_next;
  bit         pend [N];
  bit         p_we [N];
  logic [7:0] p_addr [N];
  logic [7:0] p_data [N];
  int         tally [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    rr_next = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; last_read[i] = 8'h00; tally[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN  = 1'b1;
    mem_req = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(mem_ready), 32'(0));
    chk("reset_read", 32'(mem_read), 32'(0));
    resetN = 1'b0;
    clear_model();
  endtask

  task automatic issue(input int c, input bit we, input logic [7:0] a, input logic [7:0] d);
    pend[c] = 1'b1; p_we[c] = we; p_addr[c] = a; p_data[c] = d;
    mem_we[c]              = we;
    mem_addr[c*AW +: AW]   = a;
    mem_write[c*DW +: DW]  = d;
    mem_req[c]             = 1'b1;
  endtask

  function automatic int exp_winner();
    for (int off = 0; off < N; off++) begin
      if (pend[(rr_next + off) % N]) return (rr_next + off) % N;
    end
    return -1;
  endfunction

  // Waits for one completion, checks it against the model, retires it.
  task automatic wait_ready(output int core, output int waited);
    logic [7:0] e;
    int ew;
    core = -1;
    waited = 0;
    for (int t = 0; t < 20 && core < 0; t++) begin
      @(negedge clk);
      waited++;
      for (int i = N - 1; i >= 0; i--) if (mem_ready[i]) core = i;
    end
    if (core < 0) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=none expected=pulse");
      return;
    end
    chk("ready_onehot", 32'($onehot(mem_ready)), 32'(1));
    ew = exp_winner();
    chk("winner", 32'(core), 32'(ew));
    for (int j = 0; j < N; j++) begin
      e = (j == core && !p_we[core]) ? ref_mem[p_addr[core]] : last_read[j];
      chk($sformatf("read_port%0d", j), 32'(mem_read[j*DW +: DW]), 32'(e));
    end
    if (p_we[core]) begin
      ref_mem[p_addr[core]] = p_data[core];
      written[p_addr[core]] = 1'b1;
    end else begin
      last_read[core] = ref_mem[p_addr[core]];
    end
    rr_next = (core + 1) % N;
    tally[core]++;
    pend[core] = 1'b0;
    mem_req[core] = 1'b0;
    @(negedge clk);
    chk("pulse_width", 32'(mem_ready), 32'(0));
  endtask

  initial begin
    int c, w, prev_cyc, issued, done, sum;
    logic [7:0] a;
    bit we;
    bit any;
    resetN    = 1'b1;
    mem_req   = '0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_write = '0;
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    clear_model();
    do_reset();

    // Single core write then read, latency from the request edge.
    issue(0, 1'b1, 8'h10, 8'hA5);
    wait_ready(c, w);
    chk("wr_latency", 32'(w), 32'(2));
    issue(0, 1'b0, 8'h10, 8'h00);
    wait_ready(c, w);
    chk("rd_latency", 32'(w), 32'(2));
    chk("rd_a5", 32'(mem_read[0 +: DW]), 32'(8'hA5));

    // Cross-core write then read.
    issue(1, 1'b1, 8'h20, 8'h3C);
    wait_ready(c, w);
    issue(2, 1'b0, 8'h20, 8'h00);
    wait_ready(c, w);
    chk("xcore_3c", 32'(mem_read[2*DW +: DW]), 32'(8'h3C));

    // All three at once, twice: fixed 0,1,2 order.
    for (int r = 0; r < 2; r++) begin
      issue(0, 1'b0, 8'h10, 8'h00);
      issue(1, 1'b0, 8'h20, 8'h00);
      issue(2, 1'b0, 8'h10, 8'h00);
      for (int k = 0; k < 3; k++) begin
        wait_ready(c, w);
        chk($sformatf("rr_order_r%0d_k%0d", r, k), 32'(c), 32'(k));
      end
    end

    // Core2 back-to-back writes then readback.
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      issue(2, 1'b1, 8'(k), 8'(k + 1));
      wait_ready(c, w);
      if (k > 0) chk("b2b_spacing", 32'(cyc - 1 - prev_cyc), 32'(3));
      prev_cyc = cyc - 1;
    end
    for (int k = 0; k < 5; k++) begin
      issue(2, 1'b0, 8'(k), 8'h00);
      wait_ready(c, w);
      chk($sformatf("readback_%0d", k), 32'(mem_read[2*DW +: DW]), 32'(k + 1));
    end

    // Reset during core1's ACCESS: no pulse, no write, pointer back to 0.
    issue(1, 1'b1, 8'h20, 8'hEE);
    @(posedge clk);
    @(negedge clk);
    resetN  = 1'b1;
    mem_req = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(mem_ready), 32'(0));
    end
    chk("abort_read_clr", 32'(mem_read), 32'(0));
    resetN = 1'b0;
    clear_model();
    issue(1, 1'b0, 8'h20, 8'h00);
    issue(2, 1'b0, 8'h20, 8'h00);
    wait_ready(c, w);
    chk("post_reset_first", 32'(c), 32'(1));
    chk("abort_no_write", 32'(mem_read[DW +: DW]), 32'(8'h3C));
    wait_ready(c, w);
    chk("post_reset_second", 32'(c), 32'(2));

    // 200 random transactions across the cores.
    do_reset();
    issued = 0;
    done   = 0;
    while (done < 200) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && issued < 200 && $urandom_range(0, 1) == 1) begin
          a  = 8'($urandom_range(0, 255));
          we = written[a] ? 1'($urandom_range(0, 1)) : 1'b1;
          issue(k, we, a, 8'($urandom_range(0, 255)));
          issued++;
        end
      end
      any = 1'b0;
      for (int k = 0; k < N; k++) any |= pend[k];
      if (!any) begin
        c = $urandom_range(0, N - 1);
        a = 8'($urandom_range(0, 255));
        issue(c, 1'b1, a, 8'($urandom_range(0, 255)));
        issued++;
      end
      wait_ready(c, w);
      if (c < 0) break;
      done++;
    end

`ifdef MP_SYS_ACCESS_COUNT_EN
    sum = 0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("grant_count_%0d", k), 32'(grant_count[k*16 +: 16]), 32'(tally[k]));
      sum += int'(grant_count[k*16 +: 16]);
    end
    chk("grant_count_sum", 32'(sum), 32'(200));
`else
    sum = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mp_mem_system.md
Name: mp_mem_system

Overview:
- N-core shared-memory subsystem: each core's instruction unit (IU) issues byte read/write requests on its own request port.
- A round-robin arbiter serializes the requests into a single-ported byte memory inside the block.
- Per-core ready pulse returns completion and read data.
- Sits between the core IUs and the backing store; the memory interface unit (MIU) side of the iu-to-miu link.

Parameters:
- N, 3, number of requester ports.
- ADDR_W, 8, byte address width; memory depth 2**ADDR_W.
- DATA_W, 8, data width (byte).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetN  in  1  reset: synchronous, active-high (asserted when 1; the port name is kept as the codebase names it).
- mem_req  in  N  per-core request valid, level, held until ready.
- mem_we  in  N  per-core write enable (1 = write, 0 = read).
- mem_addr  in  N*ADDR_W  per-core byte address; slice i is bits [i*ADDR_W +: ADDR_W].
- mem_write  in  N*DATA_W  per-core write data.
- mem_ready  out  N  per-core one-cycle completion pulse.
- mem_read  out  N*DATA_W  per-core read data; valid in the cycle mem_ready[i] = 1.

Behaviour:
- Reset (resetN = 1 at a clk edge):
  - mem_ready = 0; mem_read = 0.
  - FSM = IDLE; RR pointer = 0.
  - Memory contents are NOT cleared; the bench must write before reading.
- FSM states and transitions:
  - IDLE: if any mem_req, the arbiter picks a winner, latches its we/addr/wdata/id, then goes to ACCESS.
  - ACCESS: performs the write or reads the byte; asserts mem_ready[id] for exactly one cycle. For a read, mem_read[id] = mem[addr] in that same cycle. Goes to DONE.
  - DONE: one dead cycle so the requester can drop mem_req; returns to IDLE.
- Latency:
  - The request is sampled at edge k; ready is high during the cycle after edge k+1.
  - Minimum request spacing per port is 3 cycles.
- Arbitration:
  - Round-robin, starting search at pointer+1 relative to the last winner.
  - Pointer updates only on grant.
  - With no contention, one requester is served back-to-back without starvation.
  - With all N requesting continuously, grants go 0,1,2,0,...
- Requester rules:
  - Signals are held stable while mem_req = 1 until mem_ready.
  - If mem_req is still high in IDLE after DONE, it is a new request.
  - Request inputs are latched at grant, so changes after grant have no effect on the transaction.
- mem_read holds its last value per port between pulses; other ports' mem_read are unaffected.
- Write-then-read from different cores to the same address: the later grant sees the earlier write (sequential consistency through the single port).
- Reset mid-transaction: the transaction is abandoned, no ready pulse, and the memory write happens only if ACCESS has already completed.
- Address is full ADDR_W, so there is no out-of-range case.

Optional Feature:
- Macro MP_SYS_ACCESS_COUNT_EN.
- Defined:
  - Adds output port grant_count, N*16 bits: per-core count of completed transactions.
  - Each count increments in the ACCESS cycle, saturates at 16'hFFFF, and clears on reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package mp_sys_pkg holds:
  - ADDR_W and DATA_W default constants.
  - typedefs addr_t and data_t.
  - State enum {IDLE, ACCESS, DONE}.
  - core_id_t sized $clog2(N) with a minimum of 1.
- Sub-module mp_rr_arbiter (parameter N):
  - Inputs: req[N], grant_en.
  - Outputs: one-hot gnt[N], gnt_id.
  - Owns the RR pointer.
- The top holds the FSM, transaction latch and memory array.

Test Plan:
- Reset then core0 writes 8'hA5 to 8'h10, then core0 reads 8'h10 -> mem_ready[0] pulses one cycle; mem_read[0] = 8'hA5; ready arrives 2 cycles after the request edge.
- Core1 writes 8'h3C to 8'h20; core2 reads 8'h20 -> mem_read[2] = 8'h3C; mem_ready[1] never overlaps mem_ready[2].
- All three cores assert a read in the same cycle -> ready order 0,1,2; on repeat the order continues 0,1,2 with no starvation.
- Core2 alone issues 5 consecutive writes (data 1..5 to addresses 0..4), then reads them back -> data 1..5 in order; one transaction per 3 cycles.
- Assert resetN while in ACCESS for core1 -> no mem_ready pulse; after reset the first grant goes to the lowest requesting index (pointer = 0 state).
- With MP_SYS_ACCESS_COUNT_EN defined: 200 random transactions spread over the cores -> the sum of grant_count slices is 200 and each slice matches the bench's per-core tally.
